// File: rtl/disp_sched_pkg.sv
// Shared constants for the debug display scheduler and the board top level.
package disp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    ADV  = 2'd2
  } disp_state_t;

  localparam logic [7:0] DISP_BLANK       = 8'h00;
  localparam int         DWELL_CYCLES_DEF = 50_000_000;

endpackage

// File: rtl/disp_btn_sync.sv
// Two-flop synchronizer for the pre-debounced board button plus a registered
// rising-edge detector producing a single-cycle step pulse.
module disp_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step,
  output logic level
);

  logic sync1;
  logic sync2;
  logic level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_d <= 1'b0;
      step    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep this a true shift chain; blocking
      // ones would collapse the synchronizer stages into a single flop.
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= sync2;
      step    <= sync2 & ~level_d;
    end
  end

  assign level = sync2;

endmodule

// File: rtl/disp_sched.sv
// Round-robin scheduler sharing the two-digit hex display between up to eight
// byte-wide debug sources, with dwell-based rotation, manual step and freeze.
module disp_sched
  import disp_sched_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int DWELL_CYCLES = DWELL_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*N_SRC-1:0]         src_data,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic                       auto_mode,
  input  logic                       btn_next,
  input  logic                       freeze,
  output logic [7:0]                 disp_data,
  output logic [$clog2(N_SRC)-1:0]   disp_sel,
  output logic                       disp_active
);

  localparam int              SW       = $clog2(N_SRC);
  localparam int              CW       = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL_CYCLES - 1);

  disp_state_t                state_q, state_d;
  logic [SW-1:0]              sel_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [7:0]                 data_d;
  logic [N_SRC-1:0][7:0]      src_bytes;
  logic                       step;
  logic                       btn_level_unused;
  logic                       cur_valid;
  logic                       expire;
  logic                       adv_hit;
  logic [SW-1:0]              adv_idx;
  logic [SW-1:0]              cand;

  disp_btn_sync u_btn_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_next),
    .step  (step),
    .level (btn_level_unused)
  );

  assign src_bytes   = src_data;
  assign cur_valid   = src_valid[disp_sel];
  assign expire      = auto_mode && (cnt_q == CNT_LAST);
  assign disp_active = (state_q == SHOW);

  // Rotating priority search: the nearest valid index after disp_sel wins,
  // disp_sel itself is tried last so a lone source reselects itself.
  always_comb begin
    adv_hit = 1'b0;
    adv_idx = disp_sel;
    cand    = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      cand = SW'((int'(disp_sel) + i) % N_SRC);
      if (src_valid[cand]) begin
        adv_hit = 1'b1;
        adv_idx = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    sel_d   = disp_sel;
    cnt_d   = cnt_q;
    data_d  = disp_data;
    unique case (state_q)
      IDLE: begin
        data_d = DISP_BLANK;
        if (|src_valid) state_d = ADV;
      end
      ADV: begin
        cnt_d = '0;
        if (adv_hit) begin
          sel_d   = adv_idx;
          state_d = SHOW;
        end else begin
          data_d  = DISP_BLANK;
          state_d = IDLE;
        end
      end
      SHOW: begin
        if (!freeze) data_d = src_bytes[disp_sel];
        // Losing the shown source overrides freeze; step and expiry do not.
        if (!cur_valid) begin
          state_d = ADV;
        end else if (!freeze) begin
          if (step || expire) state_d = ADV;
          else if (auto_mode) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      disp_sel  <= '0;
      cnt_q     <= '0;
      disp_data <= DISP_BLANK;
    end else begin
      state_q   <= state_d;
      disp_sel  <= sel_d;
      cnt_q     <= cnt_d;
      disp_data <= data_d;
    end
  end

endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched: a negedge monitor checks every new SHOW
// entry and its dwell length against a queue of expected entries.
module tb_disp_sched;
  import disp_sched_pkg::*;

  localparam int N  = 4;
  localparam int DW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [8*N-1:0] src_data;
  logic [N-1:0]   src_valid;
  logic           auto_mode;
  logic           btn_next;
  logic           freeze;
  logic [7:0]     disp_data;
  logic [1:0]     disp_sel;
  logic           disp_active;

  always #5 clk = ~clk;

  disp_sched #(.N_SRC(N), .DWELL_CYCLES(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .auto_mode   (auto_mode),
    .btn_next    (btn_next),
    .freeze      (freeze),
    .disp_data   (disp_data),
    .disp_sel    (disp_sel),
    .disp_active (disp_active)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    int         len;   // expected SHOW length in cycles, 0 when not checked
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  bit   mon_en      = 1'b0;
  bit   pending     = 1'b0;
  bit   have_cur    = 1'b0;
  logic prev_active = 1'b0;
  int   run_len     = 0;
  int   n_pops      = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [7:0] d, input int l);
    exp_t e;
    e.sel  = s;
    e.data = d;
    e.len  = l;
    sb_q.push_back(e);
  endtask

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) check("sb_timeout", sb_q.size(), 0);
  endtask

  // Entry compare happens on the second SHOW cycle, once disp_data has loaded.
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_active = 1'b0;
      pending     = 1'b0;
      have_cur    = 1'b0;
      run_len     = 0;
    end else begin
      if (pending) begin
        pending = 1'b0;
        if (sb_q.size() == 0) begin
          check("sb_underflow", sb_q.size(), 1);
        end else begin
          cur      = sb_q.pop_front();
          have_cur = 1'b1;
          n_pops++;
          check("sb_sel", disp_sel, cur.sel);
          check("sb_data", disp_data, cur.data);
        end
      end
      if (disp_active && !prev_active) begin
        pending  = 1'b1;
        have_cur = 1'b0;
        run_len  = 1;
      end else if (disp_active) begin
        run_len++;
      end else if (prev_active && have_cur && cur.len != 0) begin
        check("dwell_len", run_len, cur.len);
      end
      prev_active = disp_active;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    src_data  = '0;
    src_valid = '0;
    auto_mode = 1'b0;
    btn_next  = 1'b0;
    freeze    = 1'b0;
    #12;
    check("rst_active", disp_active, 0);
    check("rst_data", disp_data, DISP_BLANK);
    check("rst_sel", disp_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();
    check("idle_active", disp_active, 0);
    check("idle_data", disp_data, DISP_BLANK);

    // Auto rotation over all four sources, starting after index 0.
    mon_en    = 1'b1;
    src_data  = 32'h4433_2211;
    auto_mode = 1'b1;
    push(2'd1, 8'h22, DW);
    push(2'd2, 8'h33, DW);
    push(2'd3, 8'h44, DW);
    push(2'd0, 8'h11, DW);
    push(2'd1, 8'h22, DW);
    @(negedge clk);
    src_valid = 4'hF;
    wait_sb(100);

    // Skip invalid sources, then drop the shown one.
    src_valid = 4'b1010;
    push(2'd3, 8'h44, DW);
    push(2'd1, 8'h22, DW);
    push(2'd3, 8'h44, 0);
    wait_sb(100);
    push(2'd1, 8'h22, 0);
    src_valid = 4'b0010;
    auto_mode = 1'b0;
    tick();
    check("drop_adv", disp_active, 0);
    tick();
    check("drop_sel", disp_sel, 1);
    check("drop_active", disp_active, 1);
    src_valid = 4'b1010;

    // Manual step with a held button.
    repeat (10) tick();
    check("manual_hold_sel", disp_sel, 1);
    push(2'd3, 8'h44, 0);
    btn_next = 1'b1;
    repeat (3) tick();
    check("pre_step_sel", disp_sel, 1);
    check("pre_step_active", disp_active, 1);
    tick();
    check("step_adv", disp_active, 0);
    tick();
    check("step_sel", disp_sel, 3);
    check("step_active", disp_active, 1);
    repeat (15) tick();
    check("held_sel", disp_sel, 3);
    btn_next = 1'b0;
    repeat (5) tick();

    // Freeze with auto on, new data and a button press; counter sits at 0.
    freeze          = 1'b1;
    auto_mode       = 1'b1;
    src_data[31:24] = 8'hAB;
    btn_next        = 1'b1;
    repeat (12) tick();
    check("frz_data", disp_data, 8'h44);
    check("frz_sel", disp_sel, 3);
    check("frz_active", disp_active, 1);
    btn_next = 1'b0;
    repeat (3) tick();
    push(2'd1, 8'h22, DW);
    push(2'd3, 8'hAB, DW);
    push(2'd1, 8'h22, 0);
    freeze = 1'b0;
    tick();
    check("unfrz_data", disp_data, 8'hAB);
    tick();
    tick();
    check("resume_hold_sel", disp_sel, 3);
    check("resume_hold_active", disp_active, 1);
    tick();
    check("resume_adv", disp_active, 0);
    tick();
    check("resume_sel", disp_sel, 1);

    // Step pulse lands on the dwell-expiry cycle: one advance only.
    btn_next = 1'b1;
    repeat (3) tick();
    check("sim_pre_sel", disp_sel, 1);
    tick();
    check("sim_adv", disp_active, 0);
    tick();
    check("sim_sel", disp_sel, 3);
    tick();
    check("sim_no_extra_adv", disp_active, 1);
    btn_next = 1'b0;
    tick();
    tick();
    check("sim_hold_sel", disp_sel, 3);
    wait_sb(50);

    // Reset in the middle of SHOW with all sources withdrawn.
    mon_en = 1'b0;
    tick();
    tick();
    check("pre_rst_active", disp_active, 1);
    src_valid = '0;
    rst       = 1'b1;
    #1;
    check("rst_mid_active", disp_active, 0);
    check("rst_mid_data", disp_data, DISP_BLANK);
    check("rst_mid_sel", disp_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) tick();
    check("post_rst_active", disp_active, 0);
    check("post_rst_data", disp_data, DISP_BLANK);
    check("post_rst_sel", disp_sel, 0);

    check("sb_drained", sb_q.size(), 0);
    check("sb_pops", n_pops, 13);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
